// File: rtl/booth_mult.sv
// -----------------------------------------------------------------------------
// booth_mult
//   Sequential radix-2 Booth multiplier. It computes the signed product
//   data_operandA * data_operandB and returns the low WIDTH bits of that
//   product. It also raises a flag when the full product does not fit in
//   WIDTH signed bits.
//
//   Each iteration performs one conditional add or subtract of the
//   multiplicand into the accumulator. It then shifts the whole
//   {acc, Q, q_-1} register right arithmetically by one bit.
//
//   Timing: RDY pulses WIDTH+1 cycles after the start edge.
//
// Ports
//   clock           in   1      rising-edge clock
//   reset_n         in   1      asynchronous active-low reset
//   ctrl_MULT       in   1      start strobe; operands are latched on the same edge
//   data_operandA   in   WIDTH  multiplicand M (signed)
//   data_operandB   in   WIDTH  multiplier Q (signed)
//   data_result     out  WIDTH  low WIDTH bits of A*B; held until the next completion
//   data_exception  out  1      1 when the product overflows WIDTH signed bits
//   data_resultRDY  out  1      one-cycle pulse; result and exception are valid
// -----------------------------------------------------------------------------
module booth_mult #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter reaches WIDTH once all iterations are complete.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH:0]   m_reg;     // multiplicand, sign-extended by one bit
  logic [WIDTH:0]   acc_reg;   // upper product half plus one guard bit
  logic [WIDTH-1:0] q_reg;     // multiplier; holds the low product half at the end
  logic             qm1_reg;   // Booth q_-1 bit
  logic [WIDTH-1:0] result_reg;
  logic             exc_reg;
  logic             rdy_reg;

  logic [WIDTH:0]   sum_next;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] q_next;
  logic             exc_next;

  // One Booth step. The extra accumulator bit keeps subtracting the most
  // negative multiplicand from wrapping.
  always_comb begin
    sum_next = acc_reg;
    case ({q_reg[0], qm1_reg})
      2'b01:   sum_next = acc_reg + m_reg;
      2'b10:   sum_next = acc_reg - m_reg;
      default: sum_next = acc_reg;
    endcase
    acc_next = {sum_next[WIDTH], sum_next[WIDTH:1]};
    q_next   = {sum_next[0], q_reg[WIDTH-1:1]};
  end

  // Overflow occurs when the upper half is not a pure sign extension
  // of the low half.
  assign exc_next = (acc_reg[WIDTH-1:0] != {WIDTH{q_reg[WIDTH-1]}});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      m_reg      <= '0;
      acc_reg    <= '0;
      q_reg      <= '0;
      qm1_reg    <= 1'b0;
      result_reg <= '0;
      exc_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
    end else begin
      rdy_reg <= 1'b0;
      if (ctrl_MULT) begin
        // A start in any state (re)loads the datapath and abandons
        // any operation already in flight.
        state_reg <= ST_RUN;
        cnt_reg   <= '0;
        m_reg     <= {data_operandA[WIDTH-1], data_operandA};
        acc_reg   <= '0;
        q_reg     <= data_operandB;
        qm1_reg   <= 1'b0;
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (cnt_reg == CNT_LAST) begin
              state_reg  <= ST_DONE;
              result_reg <= q_reg;
              exc_reg    <= exc_next;
              rdy_reg    <= 1'b1;
            end else begin
              acc_reg <= acc_next;
              q_reg   <= q_next;
              qm1_reg <= q_reg[0];
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          ST_DONE: state_reg <= ST_IDLE;
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_result    = result_reg;
  assign data_exception = exc_reg;
  assign data_resultRDY = rdy_reg;

endmodule

// File: tb/tb_booth_mult.sv
module tb_booth_mult;

  logic        clock;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int n_cmp = 0;
  int n_err = 0;

  booth_mult #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Reference: full 64-bit signed product via plain arithmetic.
  function automatic longint ref_prod(input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return sa * sb;
  endfunction

  function automatic logic ref_exc(input longint p);
    logic [63:0] u;
    u = p;
    return (u[63:32] != {32{u[31]}});
  endfunction

  // Drive a start now; the next rising edge is the start edge.
  // Afterwards scramble the operands, which the DUT must ignore.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    check_eq("rdy_low_after_start", 64'(data_resultRDY), 64'd0);
  endtask

  // Count edges from the start edge until RDY rises, then check the outputs.
  task automatic wait_check(input string tag, input logic [31:0] a, input logic [31:0] b);
    int     lat;
    longint p;
    logic [63:0] pu;
    lat = 0;
    p   = ref_prod(a, b);
    pu  = p;
    for (int i = 0; i < 100; i++) begin
      @(posedge clock);
      #1;
      lat++;
      if (data_resultRDY) break;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'd33);
    check_eq({tag, "_result"}, 64'(data_result), 64'(pu[31:0]));
    check_eq({tag, "_exc"}, 64'(data_exception), 64'(ref_exc(p)));
    $display("op %s: A=%h B=%h result=%h exc=%0d latency=%0d",
             tag, a, b, data_result, data_exception, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [31:0] ra;
    logic [31:0] rb;

    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_result", 64'(data_result), 64'd0);
    check_eq("reset_exc", 64'(data_exception), 64'd0);
    check_eq("reset_rdy", 64'(data_resultRDY), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // T1 to T3: directed cases, including the corners.
    start_op(32'd7, 32'hFFFFFFFD);
    wait_check("t1", 32'd7, 32'hFFFFFFFD);
    check_eq("t1_const_result", 64'(data_result), 64'h00000000FFFFFFEB);

    start_op(32'h80000000, 32'hFFFFFFFF);
    wait_check("t2", 32'h80000000, 32'hFFFFFFFF);
    check_eq("t2_const_exc", 64'(data_exception), 64'd1);

    start_op(32'h00010000, 32'h00010000);
    wait_check("t3a", 32'h00010000, 32'h00010000);
    @(negedge clock);
    start_op(32'd0, 32'd5);
    wait_check("t3b", 32'd0, 32'd5);

    // T4: a restart mid-run abandons the first operation.
    @(negedge clock);
    start_op(32'd3, 32'd4);
    pulses = 0;
    repeat (8) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    check_eq("t4_no_early_rdy", 64'(pulses), 64'd0);
    start_op(32'hFFFFFFFA, 32'd9);
    wait_check("t4", 32'hFFFFFFFA, 32'd9);
    check_eq("t4_const_result", 64'(data_result), 64'h00000000FFFFFFCA);

    // T5: reset mid-run clears the outputs at once and discards the operation.
    @(negedge clock);
    start_op(32'd5, 32'd6);
    repeat (13) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("t5_result_cleared", 64'(data_result), 64'd0);
    check_eq("t5_exc_cleared", 64'(data_exception), 64'd0);
    check_eq("t5_rdy_cleared", 64'(data_resultRDY), 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    check_eq("t5_no_rdy", 64'(pulses), 64'd0);
    start_op(32'd7, 32'hFFFFFFFD);
    wait_check("t5_after", 32'd7, 32'hFFFFFFFD);

    // T6: random pairs. Some starts are issued during the DONE cycle,
    // others after an idle gap.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(7))
        0: ra = 32'h80000000;
        1: ra = 32'h7FFFFFFF;
        2: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(7))
        0: rb = 32'h80000000;
        1: rb = 32'h7FFFFFFF;
        2: rb = 32'd0;
        default: rb = $urandom;
      endcase
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(3)) @(posedge clock);
        @(negedge clock);
      end
      start_op(ra, rb);
      wait_check("t6", ra, rb);
    end

    @(posedge clock);
    #1;
    check_eq("final_rdy_pulse_end", 64'(data_resultRDY), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
